// File: rtl/ltc2195_lvds_emu_tx.sv
`default_nettype none
// ============================================================================
// Module      : ltc2195_lvds_emu_tx
// Description : Transmit-side emulator of the LTC2195 2-lane, 16-bit serial
//               output. Accepts 16-bit sample pairs over valid/ready and
//               serializes them onto two lanes per channel, with frame (FR)
//               and data clock (DCO) generated in the receiver's format.
//               Optional build macro LTC2195_EMU_TESTPAT_EN adds a
//               test-pattern override (test_pat_en / test_pat_in).
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2195_lvds_emu_tx #(
    parameter logic [15:0] IDLE_WORD    = 16'h0000,
    parameter int          FR_HIGH_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tx_en,
    input  logic [15:0] adc0_in,
    input  logic [15:0] adc1_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [1:0]  d0_out,
    output logic [1:0]  d1_out,
    output logic        fr_out,
    output logic        dco_out,
    output logic        underrun_out,
    input  logic        underrun_clr_in
`ifdef LTC2195_EMU_TESTPAT_EN
    ,
    input  logic        test_pat_en,
    input  logic [15:0] test_pat_in
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_nxt;
    logic        w_ready;
    logic        w_use_pat;
    logic        w_capture;
    logic        w_underrun_set;
    logic [15:0] w_word0;
    logic [15:0] w_word1;
    logic [15:0] r_sh0;
    logic [15:0] r_sh1;
    logic [15:0] r_hold0;
    logic [15:0] r_hold1;

    // State and bit-counter register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
        end
    end

    // Next state, bit counter and ready; dropping tx_en aborts at once
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bit_nxt = 3'd0;
                if (tx_en) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ready     = 1'b1;
                w_state_nxt = S_RUN;
                w_bit_nxt   = 3'd0;
            end
            S_RUN: begin
                // Last bit of a frame doubles as the load slot of the next one
                w_ready   = (r_bit_cnt == 3'd7);
                w_bit_nxt = r_bit_cnt + 3'd1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bit_nxt   = 3'd0;
            end
        endcase
        if (!tx_en) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = 3'd0;
            w_ready     = 1'b0;
        end
    end

    assign sample_ready = w_ready;

    // Word selection for a load: test pattern, fresh sample, or held pair
    always_comb begin
        w_use_pat = 1'b0;
        w_word0   = sample_valid ? adc0_in : r_hold0;
        w_word1   = sample_valid ? adc1_in : r_hold1;
`ifdef LTC2195_EMU_TESTPAT_EN
        if (test_pat_en) begin
            w_use_pat = 1'b1;
            w_word0   = test_pat_in;
            w_word1   = test_pat_in;
        end
`endif
    end

    assign w_capture      = w_ready && sample_valid && !w_use_pat;
    assign w_underrun_set = w_ready && !sample_valid && !w_use_pat;

    // Hold registers remember the last accepted pair for underrun repeats
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hold0 <= IDLE_WORD;
            r_hold1 <= IDLE_WORD;
        end else if (w_capture) begin
            r_hold0 <= adc0_in;
            r_hold1 <= adc1_in;
        end
    end

    // Sticky underrun flag; a new underrun wins over a clear
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            underrun_out <= 1'b0;
        end else if (w_underrun_set) begin
            underrun_out <= 1'b1;
        end else if (underrun_clr_in) begin
            underrun_out <= 1'b0;
        end
    end

    // Lane serializers: MSB pair goes out the cycle after the load
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sh0  <= 16'd0;
            r_sh1  <= 16'd0;
            d0_out <= 2'b00;
            d1_out <= 2'b00;
        end else if (w_ready) begin
            d0_out <= w_word0[15:14];
            d1_out <= w_word1[15:14];
            r_sh0  <= {w_word0[13:0], 2'b00};
            r_sh1  <= {w_word1[13:0], 2'b00};
        end else if (w_state_nxt == S_RUN) begin
            d0_out <= r_sh0[15:14];
            d1_out <= r_sh1[15:14];
            r_sh0  <= {r_sh0[13:0], 2'b00};
            r_sh1  <= {r_sh1[13:0], 2'b00};
        end else begin
            d0_out <= 2'b00;
            d1_out <= 2'b00;
        end
    end

    // Frame marker and data clock, registered to line up with the lane bits
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fr_out  <= 1'b0;
            dco_out <= 1'b0;
        end else if (w_state_nxt == S_RUN) begin
            fr_out  <= ({29'd0, w_bit_nxt} < 32'(FR_HIGH_BITS));
            dco_out <= ~dco_out;
        end else begin
            fr_out  <= 1'b0;
            dco_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ltc2195_lvds_emu_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltc2195_lvds_emu_tx
// Description : Directed, scoreboard-based bench for ltc2195_lvds_emu_tx.
//               Expected frames are queued at each load and compared against
//               words rebuilt from the lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2195_lvds_emu_tx;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tx_en = 1'b0;
    logic [15:0] adc0_in = 16'd0;
    logic [15:0] adc1_in = 16'd0;
    logic        sample_valid = 1'b0;
    logic        underrun_clr_in = 1'b0;
    logic        test_pat_en = 1'b0;
    logic [15:0] test_pat_in = 16'd0;
    logic        sample_ready;
    logic [1:0]  d0_out;
    logic [1:0]  d1_out;
    logic        fr_out;
    logic        dco_out;
    logic        underrun_out;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [15:0] last0 = 16'h8000;
    logic [15:0] last1 = 16'h8000;
    bit          flush = 1'b0;

    ltc2195_lvds_emu_tx #(
        .IDLE_WORD    (16'h8000),
        .FR_HIGH_BITS (4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tx_en           (tx_en),
        .adc0_in         (adc0_in),
        .adc1_in         (adc1_in),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .d0_out          (d0_out),
        .d1_out          (d1_out),
        .fr_out          (fr_out),
        .dco_out         (dco_out),
        .underrun_out    (underrun_out),
        .underrun_clr_in (underrun_clr_in)
`ifdef LTC2195_EMU_TESTPAT_EN
        ,
        .test_pat_en     (test_pat_en),
        .test_pat_in     (test_pat_in)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; a load slot queues the frame it must produce
    task automatic step(input logic en, input logic v, input logic [15:0] a0,
                        input logic [15:0] a1, input logic clr, input logic exp_rdy);
        @(negedge clk_in);
        tx_en = en;
        sample_valid = v;
        adc0_in = a0;
        adc1_in = a1;
        underrun_clr_in = clr;
        #1;
        check("sample_ready", 32'(sample_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            if (test_pat_en) begin
                exp_q.push_back({test_pat_in, test_pat_in});
            end else if (v) begin
                exp_q.push_back({a0, a1});
                last0 = a0;
                last1 = a1;
            end else begin
                exp_q.push_back({last0, last1});
            end
        end
    endtask

    // From IDLE: enable cycle, then the LOAD cycle
    task automatic start(input logic v, input logic [15:0] a0, input logic [15:0] a1);
        step(1'b1, v, a0, a1, 1'b0, 1'b0);
        step(1'b1, v, a0, a1, 1'b0, 1'b1);
    endtask

    // One running frame: bits 0..6 without ready, bit 7 loads the next pair
    task automatic frame(input logic v, input logic [15:0] a0, input logic [15:0] a1,
                         input logic clr);
        step(1'b1, v, a0, a1, clr, 1'b0);
        repeat (6) step(1'b1, v, a0, a1, 1'b0, 1'b0);
        step(1'b1, v, a0, a1, 1'b0, 1'b1);
    endtask

    // Let the frame in flight finish, then disable before the next load
    task automatic drain();
        repeat (7) step(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    // Lane monitor: rebuild words per frame and check FR/DCO shape
    initial begin
        int          cnt;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [31:0] e;
        cnt = 8;
        s0  = 16'd0;
        s1  = 16'd0;
        forever begin
            @(posedge clk_in);
            #1;
            if (flush) begin
                flush = 1'b0;
                check("abort_mid_frame", 32'(cnt != 8), 32'd1);
                if (cnt != 8 && exp_q.size() > 0) void'(exp_q.pop_front());
                cnt = 8;
            end else if (cnt != 8 || fr_out === 1'b1) begin
                if (cnt == 8) cnt = 0;
                check("fr_out", 32'(fr_out), 32'(cnt < 4));
                check("dco_out", 32'(dco_out), 32'(cnt % 2 == 0));
                s0 = {s0[13:0], d0_out};
                s1 = {s1[13:0], d1_out};
                cnt++;
                if (cnt == 8) begin
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("ch0_word", {16'd0, s0}, {16'd0, e[31:16]});
                        check("ch1_word", {16'd0, s1}, {16'd0, e[15:0]});
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_d0", 32'(d0_out), 32'd0);
        check("rst_d1", 32'(d1_out), 32'd0);
        check("rst_fr", 32'(fr_out), 32'd0);
        check("rst_dco", 32'(dco_out), 32'd0);
        check("rst_underrun", 32'(underrun_out), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd0);
        rst_in = 1'b0;
        step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

        // No sample ever offered: IDLE_WORD goes out and underrun sets
        start(1'b0, 16'd0, 16'd0);
        @(posedge clk_in);
        #1;
        check("underrun_first_load", 32'(underrun_out), 32'd1);

        // Clear underrun; first real pair loads at the end of this frame
        frame(1'b1, 16'hA5C3, 16'h0F0F, 1'b1);
        check("underrun_cleared", 32'(underrun_out), 32'd0);

        // Continuous ramp, one transfer per frame
        for (int i = 0; i < 6; i++) begin
            frame(1'b1, 16'(i), 16'(i + 16'h0100), 1'b0);
        end
        check("underrun_ramp", 32'(underrun_out), 32'd0);

        // 0x1234 then three frames without valid: repeats the held pair
        frame(1'b1, 16'h1234, 16'h4321, 1'b0);
        repeat (3) frame(1'b0, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk_in);
        #1;
        check("underrun_set", 32'(underrun_out), 32'd1);
        frame(1'b1, 16'h5555, 16'hAAAA, 1'b1);
        check("underrun_clr", 32'(underrun_out), 32'd0);

        // Abort at bit_cnt = 3 of the 5555/AAAA frame
        repeat (3) step(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk_in);
        check("abort_d0", 32'(d0_out), 32'd0);
        check("abort_d1", 32'(d1_out), 32'd0);
        check("abort_fr", 32'(fr_out), 32'd0);
        check("abort_dco", 32'(dco_out), 32'd0);
        step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

        // Re-enable: full frames from LOAD
        start(1'b1, 16'hBEEF, 16'h1357);
        frame(1'b1, 16'h2468, 16'h9BDF, 1'b0);
        drain();

`ifdef LTC2195_EMU_TESTPAT_EN
        // Test pattern overrides data; offered sample consumed but discarded
        test_pat_en = 1'b1;
        test_pat_in = 16'hFFFF;
        start(1'b1, 16'h1111, 16'h2222);
        @(posedge clk_in);
        #1;
        test_pat_en = 1'b0;
        check("testpat_no_underrun", 32'(underrun_out), 32'd0);
        frame(1'b0, 16'd0, 16'd0, 1'b0);
        @(posedge clk_in);
        #1;
        check("testpat_then_underrun", 32'(underrun_out), 32'd1);
        drain();
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
